// File: rtl/gps_scenario_ctrl_if.sv
// Configuration write channel for the GPS scenario controller.
// Valid/ready handshake carrying one channel field per transfer.
interface gps_scenario_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_sat;
  logic [1:0]  cfg_field;
  logic [31:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_sat,
    output cfg_field,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sat,
    input  cfg_field,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/gps_scenario_ctrl.sv
// GPS scenario controller: double-buffered per-channel parameters,
// epoch-aligned commit and per-epoch Doppler ramping.
module gps_scenario_ctrl #(
  parameter int NSAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gps_scenario_ctrl_if.slave   cfg,
  input  logic                 commit,
  input  logic                 stop,
  input  logic                 epoch_tick,
  output logic                 emu_enable,
  output logic [32*NSAT-1:0]   freq,
  output logic [16*NSAT-1:0]   gain,
  output logic [6*NSAT-1:0]    ca_sel,
  output logic                 pending,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    APPLY
  } state_t;

  typedef struct packed {
    logic [31:0] freq;
    logic [15:0] gain;
    logic [5:0]  ca;
    logic [31:0] rate;
  } chan_t;

  state_t r_state;
  chan_t  r_sh  [NSAT];
  chan_t  r_act [NSAT];
  logic   r_emu;
  logic   r_pending;
  logic   r_ready;
  logic   r_err;

  logic w_wr;
  logic w_bad;
  logic w_ok;

  assign w_wr  = cfg.cfg_valid && r_ready;
  assign w_bad = ({1'b0, cfg.cfg_sat} >= 4'(NSAT))
              || (cfg.cfg_field == 2'd2
                  && cfg.cfg_data[5:0] > 6'd35);
  assign w_ok  = w_wr && !w_bad;

  assign cfg.cfg_ready = r_ready;
  assign emu_enable    = r_emu;
  assign pending       = r_pending;
  assign cfg_err       = r_err;

  for (genvar g = 0; g < NSAT; g++) begin : g_out
    assign freq[g*32 +: 32]  = r_act[g].freq;
    assign gain[g*16 +: 16]  = r_act[g].gain;
    assign ca_sel[g*6 +: 6]  = r_act[g].ca;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_emu     <= 1'b0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      for (int i = 0; i < NSAT; i++) begin
        r_sh[i]  <= '0;
        r_act[i] <= '0;
      end
    end else begin
      r_err <= w_wr && w_bad;

      // Writes are only possible in IDLE, so they never race APPLY
      if (w_ok) begin
        for (int i = 0; i < NSAT; i++) begin
          if (3'(i) == cfg.cfg_sat) begin
            case (cfg.cfg_field)
              2'd0: r_sh[i].freq <= cfg.cfg_data;
              2'd1: r_sh[i].gain <= cfg.cfg_data[15:0];
              2'd2: r_sh[i].ca   <= cfg.cfg_data[5:0];
              default: r_sh[i].rate <= cfg.cfg_data;
            endcase
          end
        end
      end

      if (stop) begin
        r_state   <= IDLE;
        r_emu     <= 1'b0;
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (commit) begin
              r_state   <= ARMED;
              r_pending <= 1'b1;
              r_ready   <= 1'b0;
            end else if (epoch_tick && r_emu) begin
              for (int i = 0; i < NSAT; i++) begin
                r_act[i].freq <= r_act[i].freq
                               + r_act[i].rate;
              end
            end
          end
          ARMED: begin
            // A stopped emulator has no epochs to align to
            if (epoch_tick || !r_emu) begin
              r_state <= APPLY;
            end
          end
          APPLY: begin
            for (int i = 0; i < NSAT; i++) begin
              r_act[i] <= r_sh[i];
            end
            r_emu     <= 1'b1;
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
          end
          default: begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
